// File: rtl/verdict_collector.sv
// Captures topEntity's stream outputs into timestamped records and replays each
// record as a 64-bit valid/ready beat stream: a header beat, then the active values.
module verdict_collector #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [63:0]                output_0,
  input  logic [63:0]                output_1,
  input  logic [63:0]                output_2,
  input  logic [63:0]                output_3,
  input  logic                       output_0_aktv,
  input  logic                       output_1_aktv,
  input  logic                       output_2_aktv,
  input  logic                       output_3_aktv,
  output logic [63:0]                m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [3:0]          mask;
    logic [3:0][63:0]    val;
  } rec_t;

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  state_t              state;
  logic [1:0]          idx;
  logic [TS_WIDTH-1:0] ts;
  rec_t                mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, count_next;

  rec_t       rec_in, head;
  logic [3:0] mask_in, above;
  logic       push, pop, full, accept, drop, hs, last;

  assign mask_in = {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv};
  assign rec_in  = '{ts: ts, mask: mask_in, val: {output_3, output_2, output_1, output_0}};
  assign head    = mem[rd_ptr];

  // Set bits of the head mask strictly above the current value index.
  assign above  = head.mask & (4'b1110 << idx);
  assign last   = (above == 4'b0);
  assign hs     = m_valid && m_ready;
  assign push   = en && (mask_in != 4'b0);
  assign full   = (count == CW'(DEPTH));
  assign pop    = hs && (state == DATA) && last;
  // A full FIFO still takes a record when the head is popped on the same edge.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign count_next = count + CW'(accept) - CW'(pop);

  assign fifo_count = count;
  assign m_last     = (state == DATA) && last;

  // The header carries the live overflow flag so the snapshot is taken at handshake.
  always_comb begin
    m_data = 64'b0;
    case (state)
      HEADER:  m_data = {head.mask, 11'b0, overflow, 48'(head.ts)};
      DATA:    m_data = head.val[idx];
      default: m_data = 64'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else if (en) ts <= ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (hs && state == HEADER) overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      idx     <= 2'd0;
    end else begin
      case (state)
        IDLE: if (count != '0) begin
          state   <= HEADER;
          m_valid <= 1'b1;
        end
        HEADER: if (m_ready) begin
          state <= DATA;
          idx   <= lowest(head.mask);
        end
        DATA: if (m_ready) begin
          if (!last) idx <= lowest(above);
          else if (count_next != '0) state <= HEADER;
          else begin
            state   <= IDLE;
            m_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_verdict_collector.sv
// Randomized bench for verdict_collector against a queue-based record model.
module tb_verdict_collector;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, m_ready = 1'b0;
  logic [63:0] o [4];
  logic [3:0]  ak = 4'b0;
  logic [63:0] m_data;
  logic        m_valid, m_last, overflow;
  logic [3:0]  fifo_count;

  verdict_collector #(.DEPTH(DEPTH), .TS_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .en(en),
    .output_0(o[0]), .output_1(o[1]), .output_2(o[2]), .output_3(o[3]),
    .output_0_aktv(ak[0]), .output_1_aktv(ak[1]),
    .output_2_aktv(ak[2]), .output_3_aktv(ak[3]),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0]      ts;
    logic [3:0]       mask;
    logic [3:0][63:0] val;
  } rec_t;

  rec_t        q [$];
  int          bpos;
  logic        ovf_m;
  logic [47:0] ts_m;
  int          n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Beat k of a record: 0 is the header, k>0 is the k-th active value.
  function automatic logic [63:0] beat(input rec_t r, input int k, input logic ov);
    int n = 0;
    if (k == 0) return {r.mask, 11'b0, ov, r.ts};
    for (int i = 0; i < 4; i++)
      if (r.mask[i]) begin
        n++;
        if (n == k) return r.val[i];
      end
    return 64'b0;
  endfunction

  always @(negedge clk) begin : mon
    logic hs, pop, hdr, push, drop;
    int   nb;
    rec_t r;
    if (rst) begin
      q.delete();
      bpos  = 0;
      ovf_m = 1'b0;
      ts_m  = 48'd0;
    end else begin
      check("fifo_count", 64'(fifo_count), 64'(q.size()));
      check("overflow", 64'(overflow), 64'(ovf_m));
      if (q.size() == 0) check("valid_idle", 64'(m_valid), 64'd0);
      else if (bpos > 0) check("valid_mid", 64'(m_valid), 64'd1);
      hs = m_valid && m_ready;
      pop = 1'b0;
      hdr = 1'b0;
      if (hs) begin
        if (q.size() == 0) check("spurious_beat", 64'd1, 64'd0);
        else begin
          nb = 1 + $countones(q[0].mask);
          check("m_data", m_data, beat(q[0], bpos, ovf_m));
          check("m_last", 64'(m_last), 64'(bpos == nb - 1));
          hdr = (bpos == 0);
          bpos++;
          if (bpos == nb) begin
            pop  = 1'b1;
            bpos = 0;
          end
        end
      end
      push = en && (ak != 4'b0);
      drop = push && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !drop) begin
        r.ts   = ts_m;
        r.mask = ak;
        for (int i = 0; i < 4; i++) r.val[i] = o[i];
        q.push_back(r);
      end
      if (drop) ovf_m = 1'b1;
      else if (hdr) ovf_m = 1'b0;
      if (en) ts_m = ts_m + 48'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 4; i++) o[i] = {$urandom, $urandom};
  endtask

  initial begin
    for (int i = 0; i < 4; i++) o[i] = 64'd0;
    // T1: capture at ts=10, header then single beat
    tick(); tick();
    rst = 1'b0;
    en  = 1'b1;
    repeat (10) tick();
    ak = 4'b0001; o[0] = 64'd5;
    tick();
    ak = 4'b0; m_ready = 1'b1;
    repeat (6) tick();
    check("t1_count", 64'(fifo_count), 64'd0);
    // T2: mask 1011 -> 1, -2, 7
    ak = 4'b1011; o[0] = 64'd1; o[1] = -64'sd2; o[3] = 64'd7;
    tick();
    ak = 4'b0;
    repeat (8) tick();
    // T3: overfill a stalled FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_vals();
      ak = 4'b0001 << $urandom_range(0, 3);
      tick();
    end
    ak = 4'b0;
    tick(); tick();
    check("t3_count", 64'(fifo_count), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd1);
    m_ready = 1'b1;
    repeat (40) tick();
    check("t3_ovf_clr", 64'(overflow), 64'd0);
    // T4: full FIFO, capture only in last-beat handshake cycles
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_vals();
      ak = 4'($urandom_range(1, 15));
      tick();
    end
    ak = 4'b0;
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_vals();
      ak = (m_valid && m_last) ? 4'($urandom_range(1, 15)) : 4'b0;
      tick();
    end
    ak = 4'b0;
    check("t4_ovf", 64'(overflow), 64'd0);
    repeat (80) tick();
    // T5: en low with strobes asserted
    en = 1'b0; ak = 4'hF;
    for (int i = 0; i < 100; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("t5_count", 64'(fifo_count), 64'd0);
    en = 1'b1; ak = 4'b0100; m_ready = 1'b1; rand_vals();
    tick();
    ak = 4'b0;
    repeat (10) tick();
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      en      = ($urandom_range(0, 9) < 8);
      ak      = ($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom_range(1, 15));
      m_ready = ($urandom_range(0, 9) < 6);
      rand_vals();
      tick();
    end
    // T6: reset in the middle of a record
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_vals();
      ak = 4'b1111;
      tick();
    end
    ak = 4'b0; en = 1'b0; m_ready = 1'b1;
    begin
      int i;
      for (i = 0; i < 60 && !(m_valid && m_last); i++) tick();
      check("t6_reach_data", 64'(m_valid && m_last), 64'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 64'(m_valid), 64'd0);
    check("t6_count", 64'(fifo_count), 64'd0);
    check("t6_last", 64'(m_last), 64'd0);
    tick();
    rst = 1'b0; en = 1'b1; ak = 4'b0001; rand_vals();
    tick();
    ak = 4'b0;
    repeat (6) tick();
    // Final drain, bounded
    en = 1'b0; m_ready = 1'b1;
    begin
      int i;
      for (i = 0; i < 300 && (fifo_count != 0 || m_valid); i++) tick();
      check("drain_done", 64'(fifo_count != 0 || m_valid), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
